// File: rtl/input_debounce.sv
// input_debounce: pin synchronizer plus stability filter with edge strobes and a saturating glitch counter
module input_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 16,
   parameter int INIT_LEVEL  = 0,
   parameter int INVERT      = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din,
   input  logic        glitch_clr,
   output logic        dout,
   output logic        rise,
   output logic        fall,
   output logic [15:0] glitch_cnt
);
   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic INV = INVERT[0];
   localparam logic INIT = INIT_LEVEL[0];
   localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);
   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0] cnt;
   logic s;
   logic abort;
   assign s = sync[SYNC_STAGES-1] ^ INV;
   // a pending transition that collapses back to the held level is a rejected glitch
   assign abort = (s == dout) && (cnt != '0);
   always_ff @(posedge clk) begin
      if (rst) begin
         sync       <= {SYNC_STAGES{INIT ^ INV}};
         dout       <= INIT;
         rise       <= 1'b0;
         fall       <= 1'b0;
         cnt        <= '0;
         glitch_cnt <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         rise <= 1'b0;
         fall <= 1'b0;
         if (s == dout)
            cnt <= '0;
         else if (cnt == LAST) begin
            dout <= s;
            cnt  <= '0;
            rise <= s;
            fall <= ~s;
         end else
            cnt <= cnt + 1'b1;
         if (glitch_clr)
            glitch_cnt <= '0;
         else if (abort && glitch_cnt != 16'hFFFF)
            glitch_cnt <= glitch_cnt + 16'd1;
      end
   end
endmodule
